dvp_tx: RTL and testbench

- DVP sensor emulator. It is the transmit side of the CMOS parallel camera interface.
- Produces OV5640-style frames: vsync, href and 8-bit RGB565 data, high byte first, one byte per clock.
- Pixels come from an internal pattern generator or from an external 16-bit pixel source.
- Used to drive the cmos_8_16bit capture path and the frame buffer without a real sensor. Also usable as a loopback source on a spare header.

---
 rtl/dvp_tx_if.sv | 34 +++
 rtl/dvp_tx.sv | 212 +++++++++++++++++++++
 tb/tb_dvp_tx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dvp_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : dvp_tx_if
// Purpose  : Bundles the control, pixel-source and DVP output signals of
//            dvp_tx.
// Ports    : enable, pattern_sel   - frame control (into the transmitter)
//            pix_req, pix_in       - external RGB565 pixel handshake
//            dvp_vsync, dvp_href,
//            dvp_data              - DVP camera bus (out of the transmitter)
//            frame_done            - end-of-frame pulse
//            modport master = transmitter side, modport slave = user side
// Revision : 1.0  initial release
// ============================================================================
interface dvp_tx_if;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        pix_req;
  logic [15:0] pix_in;
  logic        dvp_vsync;
  logic        dvp_href;
  logic [7:0]  dvp_data;
  logic        frame_done;

  modport master (
    input  enable, pattern_sel, pix_in,
    output pix_req, dvp_vsync, dvp_href, dvp_data, frame_done
  );

  modport slave (
    output enable, pattern_sel, pix_in,
    input  pix_req, dvp_vsync, dvp_href, dvp_data, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/dvp_tx.sv
`default_nettype none
// ============================================================================
// Module   : dvp_tx
// Purpose  : DVP sensor emulator. Generates OV5640-style frames (vsync, href,
//            RGB565 bytes high byte first, one byte per clock) from an
//            internal pattern generator or an external 16-bit pixel source.
// Ports    : clk    - byte clock
//            rst_n  - asynchronous active-low reset
//            bus    - dvp_tx_if.master (enable, pattern_sel, pix_req, pix_in,
//                     dvp_vsync, dvp_href, dvp_data, frame_done)
// Revision : 1.0  initial release
// ============================================================================
module dvp_tx #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int H_BLANK     = 256,
  parameter int VSYNC_LINES = 4,
  parameter int V_BACK      = 16,
  parameter int V_FRONT     = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  dvp_tx_if.master  bus
);

  localparam int c_line_len = 2 * H_ACTIVE + H_BLANK;
  localparam int c_hw       = $clog2(c_line_len);
  localparam int c_vw       = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int c_bar_w    = H_ACTIVE / 8;
  localparam int c_bw       = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;

  localparam logic [c_hw-1:0] c_h_last    = c_hw'(c_line_len - 1);
  localparam logic [c_hw-1:0] c_h_req0    = c_hw'(c_line_len - 2);
  localparam logic [c_hw-1:0] c_h_act     = c_hw'(2 * H_ACTIVE);
  localparam logic [c_hw-1:0] c_h_req_max = c_hw'(2 * H_ACTIVE - 4);
  localparam logic [c_bw-1:0] c_bar_last  = c_bw'(c_bar_w - 1);
  localparam logic [c_vw-1:0] c_vs_last   = c_vw'(VSYNC_LINES - 1);
  localparam logic [c_vw-1:0] c_vb_last   = c_vw'(V_BACK - 1);
  localparam logic [c_vw-1:0] c_va_last   = c_vw'(V_ACTIVE - 1);
  localparam logic [c_vw-1:0] c_vf_last   = c_vw'(V_FRONT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_hw-1:0]   r_h_cnt, w_h_nxt;
  logic [c_vw-1:0]   r_v_cnt, w_v_nxt, w_v_last;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [2:0]        r_bar, w_bar_nxt;
  logic [c_bw-1:0]   r_bar_cnt, w_bar_cnt_nxt;
  logic [7:0]        r_pix_lo, w_pix_lo_nxt;
  logic [c_hw-1:0]   w_x;
  logic [15:0]       w_bar_pix, w_pixel;
  logic              w_href_nxt, w_req_nxt, w_done_nxt, w_vsync_nxt;
  logic [7:0]        w_data_nxt;
  logic              r_vsync, r_href, r_pix_req, r_frame_done;
  logic [7:0]        r_data;

  // Frame/line sequencing
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    w_mode_nxt  = r_mode;
    w_v_last    = '0;
    case (r_state)
      S_VSYNC:  w_v_last = c_vs_last;
      S_VBACK:  w_v_last = c_vb_last;
      S_ACTIVE: w_v_last = c_va_last;
      S_VFRONT: w_v_last = c_vf_last;
      default:  w_v_last = '0;
    endcase

    if (r_state == S_IDLE) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
      if (bus.enable) begin
        w_state_nxt = S_VSYNC;
        w_mode_nxt  = bus.pattern_sel;
      end
    end else if (r_h_cnt == c_h_last) begin
      w_h_nxt = '0;
      if (r_v_cnt == w_v_last) begin
        w_v_nxt = '0;
        case (r_state)
          S_VSYNC:  w_state_nxt = S_VBACK;
          S_VBACK:  w_state_nxt = S_ACTIVE;
          S_ACTIVE: w_state_nxt = S_VFRONT;
          S_VFRONT: begin
            // enable is only honoured here, so a drop mid-frame finishes the frame
            if (bus.enable) begin
              w_state_nxt = S_VSYNC;
              w_mode_nxt  = bus.pattern_sel;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
          default:  w_state_nxt = S_IDLE;
        endcase
      end else begin
        w_v_nxt = r_v_cnt + 1'b1;
      end
    end else begin
      w_h_nxt = r_h_cnt + 1'b1;
    end
  end

  // Pixel generation. Everything below looks at the *next* counter values so
  // the registered outputs line up with the state they describe.
  always_comb begin
    w_bar_nxt     = r_bar;
    w_bar_cnt_nxt = r_bar_cnt;
    // Bar index as a wrap counter stepped on each new pixel: no divider
    if (w_h_nxt == '0) begin
      w_bar_nxt     = '0;
      w_bar_cnt_nxt = '0;
    end else if (!w_h_nxt[0] && (w_h_nxt < c_h_act)) begin
      if (r_bar_cnt == c_bar_last) begin
        w_bar_cnt_nxt = '0;
        w_bar_nxt     = r_bar + 1'b1;
      end else begin
        w_bar_cnt_nxt = r_bar_cnt + 1'b1;
      end
    end

    case (w_bar_nxt)
      3'd0:    w_bar_pix = 16'hFFFF;
      3'd1:    w_bar_pix = 16'hFFE0;
      3'd2:    w_bar_pix = 16'h07FF;
      3'd3:    w_bar_pix = 16'h07E0;
      3'd4:    w_bar_pix = 16'hF81F;
      3'd5:    w_bar_pix = 16'hF800;
      3'd6:    w_bar_pix = 16'h001F;
      default: w_bar_pix = 16'h0000;
    endcase

    w_x = w_h_nxt >> 1;
    case (r_mode)
      2'd0:    w_pixel = bus.pix_in;
      2'd1:    w_pixel = w_bar_pix;
      2'd2:    w_pixel = 16'(w_x);
      default: w_pixel = 16'hFFFF;
    endcase

    w_href_nxt   = (w_state_nxt == S_ACTIVE) && (w_h_nxt < c_h_act);
    w_data_nxt   = '0;
    w_pix_lo_nxt = r_pix_lo;
    if (w_href_nxt) begin
      if (!w_h_nxt[0]) begin
        w_data_nxt   = w_pixel[15:8];
        w_pix_lo_nxt = w_pixel[7:0];
      end else begin
        w_data_nxt   = r_pix_lo;
      end
    end

    // Request two clocks ahead of each high byte; pixel 0 of a line is
    // requested at the tail of the preceding line (last VBACK line or a
    // non-final ACTIVE line).
    w_req_nxt = (r_mode == 2'd0) && (
                  ((w_state_nxt == S_ACTIVE) && !w_h_nxt[0] && (w_h_nxt <= c_h_req_max)) ||
                  ((w_h_nxt == c_h_req0) &&
                   (((w_state_nxt == S_VBACK)  && (w_v_nxt == c_vb_last)) ||
                    ((w_state_nxt == S_ACTIVE) && (w_v_nxt != c_va_last)))));

    w_done_nxt  = (w_state_nxt == S_VFRONT) && (w_v_nxt == c_vf_last) && (w_h_nxt == c_h_last);
    w_vsync_nxt = (w_state_nxt == S_VSYNC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_h_cnt      <= '0;
      r_v_cnt      <= '0;
      r_mode       <= '0;
      r_bar        <= '0;
      r_bar_cnt    <= '0;
      r_pix_lo     <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_data       <= '0;
      r_pix_req    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_mode       <= w_mode_nxt;
      r_bar        <= w_bar_nxt;
      r_bar_cnt    <= w_bar_cnt_nxt;
      r_pix_lo     <= w_pix_lo_nxt;
      r_vsync      <= w_vsync_nxt;
      r_href       <= w_href_nxt;
      r_data       <= w_data_nxt;
      r_pix_req    <= w_req_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  assign bus.dvp_vsync  = r_vsync;
  assign bus.dvp_href   = r_href;
  assign bus.dvp_data   = r_data;
  assign bus.pix_req    = r_pix_req;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dvp_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvp_tx
// Purpose  : Directed self-checking bench for dvp_tx with a small frame
//            (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, 1/1/1 blank lines: L=20,
//            140-clock frames) and a byte-pair capture scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_dvp_tx;
  localparam int H  = 8;
  localparam int L  = 20;
  localparam int FR = 140;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dvp_tx_if bus();

  dvp_tx #(
    .H_ACTIVE(H), .V_ACTIVE(4), .H_BLANK(4),
    .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int req_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int mode, input int ln, input int x);
    logic [15:0] p;
    case (mode)
      0: p = 16'(ln * H + x);
      1: begin
        case (x / (H / 8))
          0: p = 16'hFFFF;  1: p = 16'hFFE0;  2: p = 16'h07FF;  3: p = 16'h07E0;
          4: p = 16'hF81F;  5: p = 16'hF800;  6: p = 16'h001F;  default: p = 16'h0000;
        endcase
      end
      2: p = 16'(x);
      default: p = 16'hFFFF;
    endcase
    return p;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_vsync"}, bus.dvp_vsync, 0);
    check({tag, "_href"}, bus.dvp_href, 0);
    check({tag, "_data"}, bus.dvp_data, 0);
    check({tag, "_req"}, bus.pix_req, 0);
    check({tag, "_done"}, bus.frame_done, 0);
  endtask

  // Checks one whole frame starting at its clock 0; optionally changes
  // pattern_sel or drops enable at a given clock.
  task automatic run_frame(input int mode, input int chg_k, input logic [1:0] new_sel, input int drop_k);
    int ln, h;
    logic e_hr, e_rq;
    logic [7:0] e_dt;
    logic [15:0] p;
    req_cnt = 0;
    for (int k = 0; k < FR; k++) begin
      ln = k / L;
      h  = k % L;
      e_hr = (ln >= 2) && (ln <= 5) && (h < 16);
      p = exp_pix(mode, ln - 2, h / 2);
      e_dt = e_hr ? ((h % 2 == 0) ? p[15:8] : p[7:0]) : 8'h00;
      e_rq = (mode == 0) && (((ln >= 2) && (ln <= 5) && (h % 2 == 0) && (h <= 12)) ||
                             ((h == 18) && (ln >= 1) && (ln <= 4)));
      check($sformatf("m%0d_vsync@%0d", mode, k), bus.dvp_vsync, (ln == 0));
      check($sformatf("m%0d_href@%0d", mode, k), bus.dvp_href, e_hr);
      check($sformatf("m%0d_data@%0d", mode, k), bus.dvp_data, e_dt);
      check($sformatf("m%0d_req@%0d", mode, k), bus.pix_req, e_rq);
      check($sformatf("m%0d_done@%0d", mode, k), bus.frame_done, (k == FR - 1));
      if (bus.pix_req) begin
        bus.pix_in = 16'(req_cnt);
        req_cnt++;
      end
      if (k == chg_k)  bus.pattern_sel = new_sel;
      if (k == drop_k) bus.enable = 1'b0;
      @(negedge clk);
    end
    check($sformatf("m%0d_req_total", mode), req_cnt, (mode == 0) ? 32 : 0);
  endtask

  logic [15:0] q[$];
  logic [15:0] sb_exp, sb_pix;
  logic [7:0]  sb_hi;
  logic        sb_phase;
  int          sb_words;

  initial begin
    bus.enable = 1'b0;
    bus.pattern_sel = 2'd0;
    bus.pix_in = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("idle");

    // Colour bars, then a mid-frame change to ramp, then external source
    bus.pattern_sel = 2'd1;
    bus.enable = 1'b1;
    @(negedge clk);
    run_frame(1, -1, 2'd1, -1);
    run_frame(1, 50, 2'd2, -1);
    run_frame(2, 50, 2'd0, -1);
    run_frame(0, 50, 2'd1, -1);
    // Drop enable mid-frame: frame completes, then silence
    run_frame(1, -1, 2'd1, 50);
    for (int k = 0; k < 60; k++) begin
      check_zero($sformatf("post_idle%0d", k));
      @(negedge clk);
    end

    // Asynchronous reset in the middle of an active line
    bus.enable = 1'b1;
    @(negedge clk);
    repeat (70) @(negedge clk);
    check("pre_rst_href", bus.dvp_href, 1);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    bus.enable = 1'b0;
    bus.pattern_sel = 2'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("restart_vsync_before", bus.dvp_vsync, 0);
    bus.enable = 1'b1;
    @(negedge clk);
    check("restart_vsync_first", bus.dvp_vsync, 1);

    // Capture scoreboard over 3 frames of random external pixels
    sb_phase = 1'b0;
    sb_words = 0;
    for (int k = 0; k < 3 * FR; k++) begin
      if (bus.dvp_href) begin
        if (!sb_phase) begin
          sb_hi = bus.dvp_data;
        end else begin
          sb_words++;
          check("sb_queue_nonempty", (q.size() != 0), 1);
          if (q.size() != 0) begin
            sb_exp = q.pop_front();
            check($sformatf("sb_word%0d", sb_words), {sb_hi, bus.dvp_data}, sb_exp);
          end
        end
        sb_phase = ~sb_phase;
      end else begin
        sb_phase = 1'b0;
      end
      if (bus.pix_req) begin
        sb_pix = 16'($urandom);
        q.push_back(sb_pix);
        bus.pix_in = sb_pix;
      end
      @(negedge clk);
    end
    check("sb_words", sb_words, 96);
    check("sb_left", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
